// File: rtl/generic_bus_clint_pkg.sv
// Shared definitions for the CLINT-style timer/software-interrupt peripheral:
// register offsets, bus FSM state type and the byte-lane merge helper.
package generic_bus_clint_pkg;

    // Register offsets within the 64 KiB window (word aligned)
    localparam logic [15:0] MSIP_OFF        = 16'h0000;
    localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } clint_state_t;

    // Replace each byte of old_word whose byte_en bit is set with the matching wdata byte
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [3:0]  byte_en
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/generic_bus_clint_if.sv
// Generic request/busy bus between the core (master) and a responder (slave).
interface generic_bus_clint_if;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic        busy;
    logic [31:0] rdata;

    modport master (
        output ren, wen, addr, wdata, byte_en,
        input  busy, rdata
    );

    modport slave (
        input  ren, wen, addr, wdata, byte_en,
        output busy, rdata
    );
endinterface

// File: rtl/generic_bus_clint_timer.sv
// Timer core of the CLINT: prescaler, free-running 64-bit mtime, mtimecmp
// storage and the registered timer interrupt with its falling-edge clear pulse.
// Writes arrive as per-half strobes with data already byte-merged by the bus side.
module clint_timer #(
    parameter int PRESCALE = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_wr_cmp_lo,
    input  logic        i_wr_cmp_hi,
    input  logic        i_wr_time_lo,
    input  logic        i_wr_time_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_mtime,
    output logic [63:0] o_mtimecmp,
    output logic        o_timer_int,
    output logic        o_timer_int_clear
);

    localparam logic [31:0] PRESCALE_LAST = 32'(PRESCALE - 1);

    logic [31:0] r_presc;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_timer_int;
    logic        r_timer_int_clear;
    logic        w_tick;
    logic        w_cmp_hit;

    // Tick and compare decode from current register state
    always_comb begin
        w_tick    = (r_presc == PRESCALE_LAST);
        w_cmp_hit = (r_mtime >= r_mtimecmp);
    end

    // Prescale counter: wraps from PRESCALE-1 to 0, producing one tick per wrap
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_presc <= 32'd0;
        end else if (w_tick) begin
            r_presc <= 32'd0;
        end else begin
            r_presc <= r_presc + 32'd1;
        end
    end

    // mtime: a bus write to either half wins over the tick, which is then lost
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mtime <= 64'd0;
        end else if (i_wr_time_lo) begin
            r_mtime[31:0] <= i_wdata;
        end else if (i_wr_time_hi) begin
            r_mtime[63:32] <= i_wdata;
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end else begin
            r_mtime <= r_mtime;
        end
    end

    // mtimecmp storage, reset to all ones so no interrupt fires out of reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (i_wr_cmp_lo) begin
            r_mtimecmp[31:0] <= i_wdata;
        end else if (i_wr_cmp_hi) begin
            r_mtimecmp[63:32] <= i_wdata;
        end else begin
            r_mtimecmp <= r_mtimecmp;
        end
    end

    // Registered timer level and a one-cycle pulse when it drops
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_timer_int       <= 1'b0;
            r_timer_int_clear <= 1'b0;
        end else begin
            r_timer_int       <= w_cmp_hit;
            r_timer_int_clear <= r_timer_int & ~w_cmp_hit;
        end
    end

    assign o_mtime           = r_mtime;
    assign o_mtimecmp        = r_mtimecmp;
    assign o_timer_int       = r_timer_int;
    assign o_timer_int_clear = r_timer_int_clear;

endmodule

// File: rtl/generic_bus_clint.sv
// CLINT-style peripheral on the generic bus: request FSM with configurable
// wait latency, address decode, msip and soft interrupt; the timer lives in
// clint_timer. Out-of-window or unmapped accesses complete normally, reading 0.
module generic_bus_clint
    import generic_bus_clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          LATENCY   = 1,
    parameter int          PRESCALE  = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    generic_bus_clint_if.slave        bus,
    output logic                      timer_int,
    output logic                      timer_int_clear,
    output logic                      soft_int,
    output logic                      soft_int_clear
);

    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    clint_state_t r_state;
    clint_state_t w_next_state;
    logic [3:0]   r_cnt;
    logic [3:0]   w_cnt_next;
    logic         w_capture;

    logic [31:0]  r_addr;
    logic [31:0]  r_wdata;
    logic [3:0]   r_be;
    logic         r_is_write;
    logic         r_is_read;
    logic         r_busy;

    logic         r_msip;
    logic         r_soft_int;
    logic         r_soft_int_clear;

    logic         w_in_window;
    logic [15:0]  w_offset;
    logic         w_sel_msip;
    logic         w_sel_cmp_lo;
    logic         w_sel_cmp_hi;
    logic         w_sel_time_lo;
    logic         w_sel_time_hi;
    logic [31:0]  w_reg_val;
    logic [31:0]  w_merged;
    logic         w_commit;
    logic [63:0]  w_mtime;
    logic [63:0]  w_mtimecmp;

    // Next-state and wait-counter logic for IDLE -> WAIT -> RESP -> IDLE
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.ren | bus.wen) begin
                    w_capture  = 1'b1;
                    w_cnt_next = LAT_CNT;
                    if (LAT_CNT == 4'd0) begin
                        w_next_state = RESP;
                    end else begin
                        w_next_state = WAIT;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_next_state = RESP;
                end else begin
                    w_next_state = WAIT;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // FSM state and wait counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // Capture the request once in IDLE; later input changes are ignored
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_be       <= 4'd0;
            r_is_write <= 1'b0;
            r_is_read  <= 1'b0;
        end else if (w_capture) begin
            r_addr     <= bus.addr;
            r_wdata    <= bus.wdata;
            r_be       <= bus.byte_en;
            r_is_write <= bus.wen;
            r_is_read  <= bus.ren & ~bus.wen;
        end else begin
            r_addr     <= r_addr;
            r_wdata    <= r_wdata;
            r_be       <= r_be;
            r_is_write <= r_is_write;
            r_is_read  <= r_is_read;
        end
    end

    // busy is registered and drops for exactly the RESP cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_busy <= 1'b1;
        end else begin
            r_busy <= (w_next_state != RESP);
        end
    end

    // Address decode of the captured request; byte offset bits are masked off
    always_comb begin
        w_in_window   = (r_addr[31:16] == BASE_ADDR[31:16]);
        w_offset      = r_addr[15:0] & 16'hFFFC;
        w_sel_msip    = w_in_window & (w_offset == MSIP_OFF);
        w_sel_cmp_lo  = w_in_window & (w_offset == MTIMECMP_LO_OFF);
        w_sel_cmp_hi  = w_in_window & (w_offset == MTIMECMP_HI_OFF);
        w_sel_time_lo = w_in_window & (w_offset == MTIME_LO_OFF);
        w_sel_time_hi = w_in_window & (w_offset == MTIME_HI_OFF);
    end

    // Current value of the selected register; also the base for byte merging
    always_comb begin
        w_reg_val = 32'd0;
        if (w_sel_msip) begin
            w_reg_val = {31'd0, r_msip};
        end else if (w_sel_cmp_lo) begin
            w_reg_val = w_mtimecmp[31:0];
        end else if (w_sel_cmp_hi) begin
            w_reg_val = w_mtimecmp[63:32];
        end else if (w_sel_time_lo) begin
            w_reg_val = w_mtime[31:0];
        end else if (w_sel_time_hi) begin
            w_reg_val = w_mtime[63:32];
        end else begin
            w_reg_val = 32'd0;
        end
        w_merged = merge_bytes(w_reg_val, r_wdata, r_be);
        w_commit = (r_state == RESP) & r_is_write;
    end

    // Read data is presented only during RESP of a pure read; it reflects
    // register contents in that cycle, before any same-edge tick or write
    always_comb begin
        if ((r_state == RESP) && r_is_read) begin
            bus.rdata = w_reg_val;
        end else begin
            bus.rdata = 32'd0;
        end
    end

    assign bus.busy = r_busy;

    // msip: only bit 0 is storage
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_msip <= 1'b0;
        end else if (w_commit && w_sel_msip) begin
            r_msip <= w_merged[0];
        end else begin
            r_msip <= r_msip;
        end
    end

    // Registered soft interrupt level and a one-cycle pulse when it drops
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_soft_int       <= 1'b0;
            r_soft_int_clear <= 1'b0;
        end else begin
            r_soft_int       <= r_msip;
            r_soft_int_clear <= r_soft_int & ~r_msip;
        end
    end

    assign soft_int       = r_soft_int;
    assign soft_int_clear = r_soft_int_clear;

    clint_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .CLK               (CLK),
        .RST               (RST),
        .i_wr_cmp_lo       (w_commit & w_sel_cmp_lo),
        .i_wr_cmp_hi       (w_commit & w_sel_cmp_hi),
        .i_wr_time_lo      (w_commit & w_sel_time_lo),
        .i_wr_time_hi      (w_commit & w_sel_time_hi),
        .i_wdata           (w_merged),
        .o_mtime           (w_mtime),
        .o_mtimecmp        (w_mtimecmp),
        .o_timer_int       (timer_int),
        .o_timer_int_clear (timer_int_clear)
    );

endmodule
